// File: rtl/complex_mult_pkg.sv
// complex_pkg: shared widths, saturation limits and the saturate helper for complex_mult.
package complex_pkg;
    localparam int IN_W  = 8;
    localparam int OUT_W = 2 * IN_W;
    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Overflow shows up as disagreement between the two top bits of the wide sum.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [OUT_W:0] x);
        return (x[OUT_W] == x[OUT_W-1]) ? x[OUT_W-1:0] : (x[OUT_W] ? SAT_MIN : SAT_MAX);
    endfunction
endpackage

// File: rtl/cmul_prod_stage.sv
// cmul_prod_stage: operand capture followed by a registered four-product stage with a valid pipe.
module cmul_prod_stage #(
    parameter int IN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   ar_i,
    input  logic signed [IN_W-1:0]   ai_i,
    input  logic signed [IN_W-1:0]   br_i,
    input  logic signed [IN_W-1:0]   bi_i,
    input  logic                     valid_i,
    output logic signed [2*IN_W-1:0] rr_o,
    output logic signed [2*IN_W-1:0] ii_o,
    output logic signed [2*IN_W-1:0] ri_o,
    output logic signed [2*IN_W-1:0] ir_o,
    output logic                     valid_o
);
    localparam int PW = 2 * IN_W;

    logic signed [IN_W-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [PW-1:0]   rr_q, ii_q, ri_q, ir_q;
    logic                   v1_q, v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            bi_q <= '0;
            v1_q <= 1'b0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= valid_i;
            if (valid_i) begin
                ar_q <= ar_i;
                ai_q <= ai_i;
                br_q <= br_i;
                bi_q <= bi_i;
            end
            rr_q <= PW'(ar_q) * PW'(br_q);
            ii_q <= PW'(ai_q) * PW'(bi_q);
            ri_q <= PW'(ar_q) * PW'(bi_q);
            ir_q <= PW'(ai_q) * PW'(br_q);
            v2_q <= v1_q;
        end
    end

    assign rr_o    = rr_q;
    assign ii_o    = ii_q;
    assign ri_o    = ri_q;
    assign ir_o    = ir_q;
    assign valid_o = v2_q;
endmodule

// File: rtl/complex_mult.sv
// complex_mult: three-stage pipelined signed complex multiplier with saturated, registered outputs.
module complex_mult #(
    parameter int IN_W  = complex_pkg::IN_W,
    parameter int OUT_W = complex_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  a_real,
    input  logic signed [IN_W-1:0]  a_imag,
    input  logic signed [IN_W-1:0]  b_real,
    input  logic signed [IN_W-1:0]  b_imag,
    input  logic [1:0]              data_valid,
    output logic signed [OUT_W-1:0] z_real,
    output logic signed [OUT_W-1:0] z_imag,
    output logic                    z_valid
);
    import complex_pkg::*;

    logic signed [2*IN_W-1:0] rr, ii, ri, ir;
    logic                     v2;
    logic signed [OUT_W:0]    re_d, im_d;
    logic signed [OUT_W-1:0]  z_real_q, z_imag_q;
    logic                     z_valid_q;
    logic                     unused_dv;

    // Bit 1 of data_valid is reserved and deliberately has no effect.
    assign unused_dv = data_valid[1];

    cmul_prod_stage #(.IN_W(IN_W)) u_prod (
        .clk     (clk),
        .rst_n   (rst_n),
        .ar_i    (a_real),
        .ai_i    (a_imag),
        .br_i    (b_real),
        .bi_i    (b_imag),
        .valid_i (data_valid[0]),
        .rr_o    (rr),
        .ii_o    (ii),
        .ri_o    (ri),
        .ir_o    (ir),
        .valid_o (v2)
    );

    always_comb begin
        re_d = (OUT_W+1)'(rr) - (OUT_W+1)'(ii);
        im_d = (OUT_W+1)'(ri) + (OUT_W+1)'(ir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_real_q  <= '0;
            z_imag_q  <= '0;
            z_valid_q <= 1'b0;
        end else begin
            z_valid_q <= v2;
            if (v2) begin
                z_real_q <= saturate(re_d);
                z_imag_q <= saturate(im_d);
            end
        end
    end

    assign z_real  = z_real_q;
    assign z_imag  = z_imag_q;
    assign z_valid = z_valid_q;
endmodule

// File: tb/tb_complex_mult.sv
// tb_complex_mult: randomized and directed checks of complex_mult against an integer reference model.
module tb_complex_mult;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
    logic [1:0]        data_valid = '0;
    logic signed [15:0] z_real, z_imag;
    logic              z_valid;

    int checks = 0;
    int passed = 0;
    int last_re = 0;
    int last_im = 0;
    int q_re[$];
    int q_im[$];

    complex_mult dut (
        .clk(clk), .rst_n(rst_n),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .data_valid(data_valid),
        .z_real(z_real), .z_imag(z_imag), .z_valid(z_valid)
    );

    always #5 clk = ~clk;

    function automatic int sat(int x);
        return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
    endfunction

    function automatic int exp_re(int ar, int ai, int br, int bi);
        return sat(ar * br - ai * bi);
    endfunction

    function automatic int exp_im(int ar, int ai, int br, int bi);
        return sat(ar * bi + ai * br);
    endfunction

    task automatic set_in(int ar, int ai, int br, int bi, logic [1:0] dv);
        a_real = 8'(ar);
        a_imag = 8'(ai);
        b_real = 8'(br);
        b_imag = 8'(bi);
        data_valid = dv;
    endtask

    task automatic test_reset();
        set_in(11, 22, 33, 44, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (z_valid !== 1'b0 || z_real !== 16'sd0 || z_imag !== 16'sd0)
                $display("FAIL reset_state cyc%0d: got v=%b re=%0d im=%0d, want v=0 re=0 im=0", k, z_valid, z_real, z_imag);
            else passed++;
        end
        set_in(0, 0, 0, 0, 2'b00);
        rst_n = 1'b1;
    endtask

    task automatic pulse(string name, int ar, int ai, int br, int bi);
        int er = exp_re(ar, ai, br, bi);
        int ei = exp_im(ar, ai, br, bi);
        int hits = 0;
        int lat = 0;
        @(negedge clk);
        set_in(ar, ai, br, bi, 2'b01);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) set_in(0, 0, 0, 0, 2'b00);
            if (k == 2) begin
                checks++;
                if (z_real !== 16'(last_re) || z_imag !== 16'(last_im))
                    $display("FAIL %s_hold_before: got (%0d,%0d), want (%0d,%0d)", name, z_real, z_imag, last_re, last_im);
                else passed++;
            end
            if (z_valid === 1'b1) begin
                hits++;
                if (lat == 0) begin
                    lat = k;
                    checks++;
                    if (z_real !== 16'(er)) $display("FAIL %s_real: got %0d, want %0d", name, z_real, er);
                    else passed++;
                    checks++;
                    if (z_imag !== 16'(ei)) $display("FAIL %s_imag: got %0d, want %0d", name, z_imag, ei);
                    else passed++;
                end
            end
        end
        checks++;
        if (lat !== 3) $display("FAIL %s_latency: got %0d, want 3", name, lat);
        else passed++;
        checks++;
        if (hits !== 1) $display("FAIL %s_pulses: got %0d, want 1", name, hits);
        else passed++;
        checks++;
        if (z_real !== 16'(er) || z_imag !== 16'(ei))
            $display("FAIL %s_hold_after: got (%0d,%0d), want (%0d,%0d)", name, z_real, z_imag, er, ei);
        else passed++;
        last_re = er;
        last_im = ei;
    endtask

    task automatic test_pulses();
        pulse("p1", 1, 2, 3, 4);
        pulse("p2", 2, 4, 6, 8);
        pulse("p3", 1, 3, 5, 7);
        pulse("p4", 1, 2, 1, 2);
        pulse("p5", 3, 4, 5, 6);
    endtask

    task automatic test_zero();
        pulse("zero", 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int ops[3][4] = '{'{1, 2, 3, 4}, '{2, 4, 6, 8}, '{1, 3, 5, 7}};
        int first = -1;
        int last = -1;
        int n = 0;
        int er, ei;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (z_valid === 1'b1) begin
                n++;
                if (first < 0) first = c;
                last = c;
                er = q_re.size() ? q_re.pop_front() : 99999;
                ei = q_im.size() ? q_im.pop_front() : 99999;
                checks++;
                if (z_real !== 16'(er) || z_imag !== 16'(ei))
                    $display("FAIL b2b_result%0d: got (%0d,%0d), want (%0d,%0d)", n, z_real, z_imag, er, ei);
                else passed++;
                last_re = er;
                last_im = ei;
            end
            if (c < 3) begin
                set_in(ops[c][0], ops[c][1], ops[c][2], ops[c][3], 2'b01);
                q_re.push_back(exp_re(ops[c][0], ops[c][1], ops[c][2], ops[c][3]));
                q_im.push_back(exp_im(ops[c][0], ops[c][1], ops[c][2], ops[c][3]));
            end else set_in(0, 0, 0, 0, 2'b00);
        end
        checks++;
        if (n !== 3 || first !== 3 || last !== 5)
            $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d, want n=3 first=3 last=5", n, first, last);
        else passed++;
        q_re.delete();
        q_im.delete();
    endtask

    task automatic test_extremes();
        pulse("sat_all_min", -128, -128, -128, -128);
        pulse("ext_mixed", -128, 127, 127, -128);
        pulse("ext_pos", 127, -128, 127, 127);
    endtask

    task automatic test_reserved();
        @(negedge clk);
        set_in(5, 6, 7, 8, 2'b10);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) set_in(0, 0, 0, 0, 2'b00);
            checks++;
            if (z_valid !== 1'b0 || z_real !== 16'(last_re) || z_imag !== 16'(last_im))
                $display("FAIL reserved_bit cyc%0d: got v=%b (%0d,%0d), want v=0 (%0d,%0d)", k, z_valid, z_real, z_imag, last_re, last_im);
            else passed++;
        end
    endtask

    task automatic test_reset_flush();
        @(negedge clk);
        set_in(10, 20, 30, 40, 2'b01);
        @(negedge clk);
        set_in(0, 0, 0, 0, 2'b00);
        rst_n = 1'b0;
        #1;
        checks++;
        if (z_valid !== 1'b0 || z_real !== 16'sd0 || z_imag !== 16'sd0)
            $display("FAIL async_reset: got v=%b (%0d,%0d), want v=0 (0,0)", z_valid, z_real, z_imag);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (z_valid !== 1'b0 || z_real !== 16'sd0 || z_imag !== 16'sd0)
                $display("FAIL flush cyc%0d: got v=%b (%0d,%0d), want v=0 (0,0)", k, z_valid, z_real, z_imag);
            else passed++;
        end
        last_re = 0;
        last_im = 0;
        pulse("post_reset", 7, -9, -11, 13);
    endtask

    task automatic test_random();
        int n = 0;
        int er, ei, ar, ai, br, bi;
        logic [1:0] dv;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (z_valid === 1'b1) begin
                n++;
                er = q_re.size() ? q_re.pop_front() : 99999;
                ei = q_im.size() ? q_im.pop_front() : 99999;
                checks++;
                if (z_real !== 16'(er) || z_imag !== 16'(ei))
                    $display("FAIL rand_result%0d: got (%0d,%0d), want (%0d,%0d)", n, z_real, z_imag, er, ei);
                else passed++;
                last_re = er;
                last_im = ei;
            end else begin
                checks++;
                if (z_valid !== 1'b0 || z_real !== 16'(last_re) || z_imag !== 16'(last_im))
                    $display("FAIL rand_hold cyc%0d: got v=%b (%0d,%0d), want v=0 (%0d,%0d)", c, z_valid, z_real, z_imag, last_re, last_im);
                else passed++;
            end
            if (c < 190) begin
                ar = $signed(8'($urandom));
                ai = $signed(8'($urandom));
                br = $signed(8'($urandom));
                bi = $signed(8'($urandom));
                dv = 2'($urandom);
                set_in(ar, ai, br, bi, dv);
                if (dv[0]) begin
                    q_re.push_back(exp_re(ar, ai, br, bi));
                    q_im.push_back(exp_im(ar, ai, br, bi));
                end
            end else set_in(0, 0, 0, 0, 2'b00);
        end
        checks++;
        if (q_re.size() !== 0) $display("FAIL rand_drain: got %0d pending results, want 0", q_re.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_pulses();
        test_zero();
        test_back_to_back();
        test_extremes();
        test_reserved();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
